// File: rtl/y86_seq_core_if.sv
// Bus bundle for the Y86-64 SEQ core: program-load port, external data
// memory return path, and the architectural observation outputs.
interface y86_seq_core_if;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [7:0]  imem_wdata;
  logic [63:0] valM;

  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valE;
  logic        cnd;
  logic        instr_valid;
  logic        imem_error;
  logic [1:0]  stat;

  modport master (
    output imem_we, imem_waddr, imem_wdata, valM,
    input  pc, icode, ifun, rA, rB, valC, valP, valA, valB, valE,
    input  cnd, instr_valid, imem_error, stat
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata, valM,
    output pc, icode, ifun, rA, rB, valC, valP, valA, valB, valE,
    output cnd, instr_valid, imem_error, stat
  );
endinterface

// File: rtl/y86_seq_core.sv
// Single-cycle Y86-64 SEQ core. Fetch, decode and execute are combinational
// from the PC and architectural state; PC, register file and condition codes
// commit together on the rising edge whenever the status is AOK.
module y86_seq_core (
  input logic            clk,
  input logic            reset,
  y86_seq_core_if.slave  bus
);
  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [1:0] S_AOK  = 2'd0;
  localparam logic [1:0] S_HLT  = 2'd1;
  localparam logic [1:0] S_ADR  = 2'd2;
  localparam logic [1:0] S_INS  = 2'd3;

  logic [7:0]  imem [0:1023];
  logic [63:0] regs [0:14];
  logic [63:0] pc_r;
  logic        zf, sf, of;

  logic [7:0]  fb [0:9];
  logic [3:0]  icode, ifun, ra, rb;
  logic [3:0]  len;
  logic        need_regids;
  logic        instr_valid, imem_error;
  logic [63:0] val_c, val_p, val_a, val_b, val_e;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic        cond_raw, cnd;
  logic        new_zf, new_sf, new_of;
  logic [63:0] new_pc;
  logic [1:0]  stat;

  // Program load port; instruction memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  // Fetch the ten bytes starting at the PC; bytes past the end read as zero.
  always_comb begin
    logic [63:0] a;
    a = 64'd0;
    for (int k = 0; k < 10; k++) begin
      a = pc_r + 64'(k);
      fb[k] = (a < 64'd1024) ? imem[a[9:0]] : 8'h00;
    end
  end

  // Instruction split, length, constant word and range check.
  always_comb begin
    icode       = fb[0][7:4];
    ifun        = fb[0][3:0];
    instr_valid = (icode <= 4'hB);
    need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    ra          = need_regids ? fb[1][7:4] : R_NONE;
    rb          = need_regids ? fb[1][3:0] : R_NONE;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;
    endcase
    case (icode)
      4'h7, 4'h8:       val_c = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
      4'h3, 4'h4, 4'h5: val_c = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
      default:          val_c = 64'd0;
    endcase
    val_p = pc_r + {60'd0, len};
    // len is at most 10, so the subtraction cannot underflow
    imem_error = (pc_r > (64'd1024 - {60'd0, len}));
  end

  // Decode: operand sources and register reads; 0xF reads as zero.
  always_comb begin
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = ra;
      4'h9, 4'hB:             src_a = R_RSP;
      default:                src_a = R_NONE;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       src_b = rb;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = R_RSP;
      default:                src_b = R_NONE;
    endcase
    val_a = (src_a == R_NONE) ? 64'd0 : regs[src_a];
    val_b = (src_b == R_NONE) ? 64'd0 : regs[src_b];
  end

  // Execute: ALU result and the condition codes an OPq would produce.
  always_comb begin
    case (icode)
      4'h2:       val_e = val_a;
      4'h3:       val_e = val_c;
      4'h4, 4'h5: val_e = val_b + val_c;
      4'h6: begin
        case (ifun)
          4'h0:    val_e = val_b + val_a;
          4'h1:    val_e = val_b - val_a;
          4'h2:    val_e = val_b & val_a;
          4'h3:    val_e = val_b ^ val_a;
          default: val_e = 64'd0;
        endcase
      end
      4'h8, 4'hA: val_e = val_b - 64'd8;
      4'h9, 4'hB: val_e = val_b + 64'd8;
      default:    val_e = 64'd0;
    endcase
    new_zf = (val_e == 64'd0);
    new_sf = val_e[63];
    case (ifun)
      4'h0:    new_of = (val_a[63] == val_b[63]) && (val_e[63] != val_a[63]);
      4'h1:    new_of = (val_b[63] != val_a[63]) && (val_e[63] != val_b[63]);
      default: new_of = 1'b0;
    endcase
  end

  // Branch / conditional-move condition from the current flags.
  always_comb begin
    case (ifun)
      4'h0:    cond_raw = 1'b1;
      4'h1:    cond_raw = (sf ^ of) | zf;
      4'h2:    cond_raw = sf ^ of;
      4'h3:    cond_raw = zf;
      4'h4:    cond_raw = ~zf;
      4'h5:    cond_raw = ~(sf ^ of);
      4'h6:    cond_raw = ~(sf ^ of) & ~zf;
      default: cond_raw = 1'b0;
    endcase
    cnd = ((icode == 4'h2) || (icode == 4'h7)) ? cond_raw : 1'b0;
  end

  // Writeback destinations, next PC and status.
  always_comb begin
    case (icode)
      4'h3, 4'h6:             dst_e = rb;
      4'h2:                   dst_e = cnd ? rb : R_NONE;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = R_RSP;
      default:                dst_e = R_NONE;
    endcase
    dst_m = (icode == 4'h5 || icode == 4'hB) ? ra : R_NONE;
    case (icode)
      4'h8:    new_pc = val_c;
      4'h7:    new_pc = cnd ? val_c : val_p;
      4'h9:    new_pc = bus.valM;
      default: new_pc = val_p;
    endcase
    if (imem_error)        stat = S_ADR;
    else if (!instr_valid) stat = S_INS;
    else if (icode == 4'h0) stat = S_HLT;
    else                   stat = S_AOK;
  end

  // Architectural commit; a non-AOK status freezes everything until reset.
  // The M write is issued after the E write so popq %rsp keeps the loaded value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= 64'd0;
      for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (stat == S_AOK) begin
      pc_r <= new_pc;
      if (dst_e != R_NONE) regs[dst_e] <= val_e;
      if (dst_m != R_NONE) regs[dst_m] <= bus.valM;
      if (icode == 4'h6) begin
        zf <= new_zf;
        sf <= new_sf;
        of <= new_of;
      end
    end
  end

  assign bus.pc          = pc_r;
  assign bus.icode       = icode;
  assign bus.ifun        = ifun;
  assign bus.rA          = ra;
  assign bus.rB          = rb;
  assign bus.valC        = val_c;
  assign bus.valP        = val_p;
  assign bus.valA        = val_a;
  assign bus.valB        = val_b;
  assign bus.valE        = val_e;
  assign bus.cnd         = cnd;
  assign bus.instr_valid = instr_valid;
  assign bus.imem_error  = imem_error;
  assign bus.stat        = stat;
endmodule

// File: tb/tb_y86_seq_core.sv
// Self-checking bench for y86_seq_core: small programs are loaded under
// reset, expectations are queued per step, and each step's outputs and
// architectural state are compared once the core has advanced to it.
module tb_y86_seq_core;
  logic clk;
  logic reset;

  y86_seq_core_if bus ();

  y86_seq_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_PC    = 0;
  localparam int K_VALC  = 1;
  localparam int K_VALE  = 2;
  localparam int K_VALP  = 3;
  localparam int K_STAT  = 4;
  localparam int K_CND   = 5;
  localparam int K_ZF    = 6;
  localparam int K_SF    = 7;
  localparam int K_OF    = 8;
  localparam int K_IMERR = 9;
  localparam int K_ICODE = 10;
  localparam int K_REG   = 100;

  typedef struct {
    string       name;
    int          step;
    int          kind;
    logic [63:0] val;
  } exp_t;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } pbyte_t;

  exp_t        sb[$];
  pbyte_t      pq[$];
  logic [63:0] valm_at [0:15];
  logic        rst_at  [0:15];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic put(input int a, input logic [7:0] d);
    pq.push_back('{10'(a), d});
  endtask

  task automatic put_q(input int a, input logic [63:0] v);
    for (int k = 0; k < 8; k++) put(a + k, v[8*k +: 8]);
  endtask

  task automatic want(input int s, input string n, input int k, input logic [63:0] v);
    sb.push_back('{n, s, k, v});
  endtask

  function automatic logic [63:0] observe(input int kind);
    logic [3:0] ri;
    ri = 4'(kind - K_REG);
    case (kind)
      K_PC:    return bus.pc;
      K_VALC:  return bus.valC;
      K_VALE:  return bus.valE;
      K_VALP:  return bus.valP;
      K_STAT:  return {62'd0, bus.stat};
      K_CND:   return {63'd0, bus.cnd};
      K_ZF:    return {63'd0, dut.zf};
      K_SF:    return {63'd0, dut.sf};
      K_OF:    return {63'd0, dut.of};
      K_IMERR: return {63'd0, bus.imem_error};
      K_ICODE: return {60'd0, bus.icode};
      default: return dut.regs[ri];
    endcase
  endfunction

  // Load the queued program bytes with reset held, then release reset.
  task automatic boot();
    reset = 1'b1;
    bus.valM = 64'd0;
    for (int i = 0; i < pq.size(); i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = pq[i].addr;
      bus.imem_wdata = pq[i].data;
      @(negedge clk);
    end
    bus.imem_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pq.delete();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      valm_at[i] = 64'd0;
      rst_at[i]  = 1'b0;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [63:0] obs;
    put(0, 8'h30); put(1, 8'hF2); put_q(2, 64'd10);
    put(10, 8'h00);
    boot();
    want(0, "rst_pc", K_PC, 64'd0);
    want(0, "rst_zf", K_ZF, 64'd1);
    want(0, "rst_sf", K_SF, 64'd0);
    want(0, "rst_of", K_OF, 64'd0);
    for (int r = 0; r < 15; r++) want(0, $sformatf("rst_r%0d", r), K_REG + r, 64'd0);
    want(0, "irm_icode", K_ICODE, 64'd3);
    want(0, "irm_valc", K_VALC, 64'd10);
    want(0, "irm_vale", K_VALE, 64'd10);
    want(0, "irm_valp", K_VALP, 64'd10);
    want(0, "irm_stat", K_STAT, 64'd0);
    want(1, "irm_r2", K_REG + 2, 64'd10);
    want(1, "irm_pc", K_PC, 64'd10);
    want(1, "hlt_stat", K_STAT, 64'd1);
    want(2, "hlt_pc_hold", K_PC, 64'd10);
    want(2, "hlt_stat_hold", K_STAT, 64'd1);
    for (int s = 0; s <= 2; s++) begin
      while (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        n_checks++;
        if (obs !== e.val) $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", e.name, s, obs, e.val);
        else n_pass++;
      end
      bus.valM = valm_at[s];
      reset = rst_at[s];
      @(negedge clk);
    end
  endtask

  task automatic test_opq_sub();
    exp_t e;
    logic [63:0] obs;
    put(0, 8'h30);  put(1, 8'hF2);  put_q(2, 64'd10);
    put(10, 8'h30); put(11, 8'hF3); put_q(12, 64'd3);
    put(20, 8'h61); put(21, 8'h23);
    put(22, 8'h72); put_q(23, 64'h40);
    put(64, 8'h00);
    boot();
    want(0, "sub_pc0", K_PC, 64'd0);
    want(2, "sub_r3_init", K_REG + 3, 64'd3);
    want(2, "sub_vale", K_VALE, 64'hFFFF_FFFF_FFFF_FFF9);
    want(3, "sub_r3", K_REG + 3, 64'hFFFF_FFFF_FFFF_FFF9);
    want(3, "sub_sf", K_SF, 64'd1);
    want(3, "sub_zf", K_ZF, 64'd0);
    want(3, "sub_of", K_OF, 64'd0);
    want(3, "jl_cnd", K_CND, 64'd1);
    want(3, "jl_valc", K_VALC, 64'h40);
    want(3, "jl_valp", K_VALP, 64'd31);
    want(4, "jl_pc", K_PC, 64'h40);
    want(4, "jl_stat", K_STAT, 64'd1);
    for (int s = 0; s <= 4; s++) begin
      while (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        n_checks++;
        if (obs !== e.val) $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", e.name, s, obs, e.val);
        else n_pass++;
      end
      bus.valM = valm_at[s];
      reset = rst_at[s];
      @(negedge clk);
    end
  endtask

  task automatic test_cmov();
    exp_t e;
    logic [63:0] obs;
    put(0, 8'h30);  put(1, 8'hF2);  put_q(2, 64'd5);
    put(10, 8'h30); put(11, 8'hF3); put_q(12, 64'd5);
    put(20, 8'h61); put(21, 8'h23);
    put(22, 8'h30); put(23, 8'hF4); put_q(24, 64'd7);
    put(32, 8'h23); put(33, 8'h24);
    put(34, 8'h30); put(35, 8'hF6); put_q(36, 64'd9);
    put(44, 8'h24); put(45, 8'h26);
    put(46, 8'h00);
    boot();
    want(3, "cmv_zf", K_ZF, 64'd1);
    want(3, "cmv_r3_zero", K_REG + 3, 64'd0);
    want(4, "cmove_cnd", K_CND, 64'd1);
    want(4, "cmove_r4_before", K_REG + 4, 64'd7);
    want(5, "cmove_r4", K_REG + 4, 64'd5);
    want(6, "cmovne_cnd", K_CND, 64'd0);
    want(7, "cmovne_r6", K_REG + 6, 64'd9);
    want(7, "cmovne_pc", K_PC, 64'd46);
    for (int s = 0; s <= 7; s++) begin
      while (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        n_checks++;
        if (obs !== e.val) $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", e.name, s, obs, e.val);
        else n_pass++;
      end
      bus.valM = valm_at[s];
      reset = rst_at[s];
      @(negedge clk);
    end
  endtask

  task automatic test_call_ret();
    exp_t e;
    logic [63:0] obs;
    put(0, 8'h30);  put(1, 8'hF4); put_q(2, 64'h100);
    put(10, 8'h80); put_q(11, 64'h20);
    put(32, 8'h90);
    put(64, 8'hB0); put(65, 8'h4F);
    put(66, 8'h00);
    boot();
    valm_at[2] = 64'h40;
    valm_at[3] = 64'h1234;
    want(1, "call_vale", K_VALE, 64'hF8);
    want(1, "call_valp", K_VALP, 64'h13);
    want(2, "call_rsp", K_REG + 4, 64'hF8);
    want(2, "call_pc", K_PC, 64'h20);
    want(2, "ret_vale", K_VALE, 64'h100);
    want(3, "ret_pc", K_PC, 64'h40);
    want(3, "ret_rsp", K_REG + 4, 64'h100);
    want(4, "poprsp_m_wins", K_REG + 4, 64'h1234);
    want(4, "poprsp_pc", K_PC, 64'h42);
    for (int s = 0; s <= 4; s++) begin
      while (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        n_checks++;
        if (obs !== e.val) $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", e.name, s, obs, e.val);
        else n_pass++;
      end
      bus.valM = valm_at[s];
      reset = rst_at[s];
      @(negedge clk);
    end
  endtask

  task automatic test_ins();
    exp_t e;
    logic [63:0] obs;
    put(0, 8'hC0);
    boot();
    want(0, "ins_stat", K_STAT, 64'd3);
    want(0, "ins_imerr", K_IMERR, 64'd0);
    want(1, "ins_pc_frozen", K_PC, 64'd0);
    want(1, "ins_stat_hold", K_STAT, 64'd3);
    for (int s = 0; s <= 1; s++) begin
      while (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        n_checks++;
        if (obs !== e.val) $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", e.name, s, obs, e.val);
        else n_pass++;
      end
      bus.valM = valm_at[s];
      reset = rst_at[s];
      @(negedge clk);
    end
  endtask

  task automatic test_adr();
    exp_t e;
    logic [63:0] obs;
    put(0, 8'h70); put_q(1, 64'h3FC);
    put(1020, 8'h30); put(1021, 8'hF2); put(1022, 8'h00); put(1023, 8'h00);
    boot();
    want(0, "jmp_cnd", K_CND, 64'd1);
    want(0, "jmp_stat", K_STAT, 64'd0);
    want(1, "adr_pc", K_PC, 64'h3FC);
    want(1, "adr_imerr", K_IMERR, 64'd1);
    want(1, "adr_stat", K_STAT, 64'd2);
    want(2, "adr_pc_frozen", K_PC, 64'h3FC);
    want(2, "adr_r2_untouched", K_REG + 2, 64'd0);
    for (int s = 0; s <= 2; s++) begin
      while (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        n_checks++;
        if (obs !== e.val) $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", e.name, s, obs, e.val);
        else n_pass++;
      end
      bus.valM = valm_at[s];
      reset = rst_at[s];
      @(negedge clk);
    end
  endtask

  task automatic test_overflow_reset();
    exp_t e;
    logic [63:0] obs;
    put(0, 8'h30);  put(1, 8'hF2);  put_q(2, 64'h7FFF_FFFF_FFFF_FFFF);
    put(10, 8'h30); put(11, 8'hF3); put_q(12, 64'd1);
    put(20, 8'h60); put(21, 8'h32);
    put(22, 8'h10); put(23, 8'h10); put(24, 8'h00);
    boot();
    rst_at[2] = 1'b1;
    want(2, "add_vale", K_VALE, 64'h8000_0000_0000_0000);
    want(3, "midrst_pc", K_PC, 64'd0);
    want(3, "midrst_zf", K_ZF, 64'd1);
    want(3, "midrst_of", K_OF, 64'd0);
    for (int r = 0; r < 15; r++) want(3, $sformatf("midrst_r%0d", r), K_REG + r, 64'd0);
    want(5, "rerun_pc", K_PC, 64'd20);
    want(6, "add_of", K_OF, 64'd1);
    want(6, "add_sf", K_SF, 64'd1);
    want(6, "add_zf", K_ZF, 64'd0);
    want(6, "add_r2", K_REG + 2, 64'h8000_0000_0000_0000);
    want(8, "nop_pc", K_PC, 64'd24);
    want(8, "end_stat", K_STAT, 64'd1);
    for (int s = 0; s <= 8; s++) begin
      while (sb.size() > 0 && sb[0].step == s) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        n_checks++;
        if (obs !== e.val) $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", e.name, s, obs, e.val);
        else n_pass++;
      end
      bus.valM = valm_at[s];
      reset = rst_at[s];
      @(negedge clk);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = 10'd0;
    bus.imem_wdata = 8'd0;
    bus.valM       = 64'd0;
    @(negedge clk);
    test_reset();
    test_opq_sub();
    test_cmov();
    test_call_ret();
    test_ins();
    test_adr();
    test_overflow_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/y86_seq_core.md
# y86_seq_core

Single-cycle Y86-64 core datapath covering fetch, decode, execute and writeback/PC-update for the sequential (SEQ) processor. Holds the PC, a byte-addressed instruction memory, the 15-entry register file and the condition codes. Data memory sits outside the block: it receives `valE`/`valA` and returns `valM` in the same cycle.

## Interface
- No parameters. Instruction memory is fixed at 1024 bytes; the datapath is fixed at 64 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_we  in  1  instruction-memory byte write enable (program load).
- imem_waddr  in  10  program-load byte address.
- imem_wdata  in  8  program-load byte.
- valM  in  64  data read from external memory (mrmovq, popq, ret).
- pc  out  64  current PC.
- icode, ifun  out  4 each  fetched opcode and function.
- rA, rB  out  4 each  register specifiers; 0xF when absent.
- valC  out  64  constant word, little-endian.
- valP  out  64  address of the next sequential instruction.
- valA, valB  out  64  decoded operands.
- valE  out  64  ALU result.
- cnd  out  1  condition result.
- instr_valid  out  1  icode is legal.
- imem_error  out  1  fetch address is out of range.
- stat  out  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.

## Operation
- **Fetch**
  - Byte0 = {icode, ifun}. If the instruction needs registers, byte1 = {rA, rB}.
  - valC comes from the next 8 bytes.
  - Instruction lengths:
    - 1 byte: halt(0), nop(1), ret(9).
    - 2 bytes: cmovXX(2), OPq(6), pushq(A), popq(B).
    - 9 bytes: jXX(7), call(8).
    - 10 bytes: irmovq(3), rmmovq(4), mrmovq(5).
  - valP = pc + length.
  - imem_error = 1 if any byte of the instruction lies at or above address 1024.
  - instr_valid = 0 for icode above 0xB.
- **Decode** (register 4 = rsp)
  - srcA = rA for icode 2/4/6/A; rsp for 9/B; otherwise 0xF.
  - srcB = rB for 4/5/6; rsp for 8/9/A/B; otherwise 0xF.
  - A source of 0xF reads 0.
- **Execute** (valE by icode)
  - 2: valA.
  - 3: valC.
  - 4/5: valB + valC.
  - 6: ALU per ifun: 0 add (valB + valA), 1 sub (valB − valA), 2 and, 3 xor.
  - 8/A: valB − 8.
  - 9/B: valB + 8.
  - All arithmetic wraps modulo 2^64.
- **Condition codes**
  - ZF, SF and OF update only for OPq.
  - Add overflow: operands have the same sign and the result sign differs.
  - Sub overflow: valB and valA signs differ and the result sign differs from valB.
- **cnd** (for icode 2 and 7) by ifun, from the current CCs:
  - 0 always.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - Illegal ifun gives cnd = 0. For other icodes cnd = 0.
- **Writeback**
  - dstE = rB for 3 and 6, and for 2 only when cnd = 1; rsp for 8/9/A/B.
  - dstM = rA for 5/B.
  - If dstE equals dstM (popq %rsp), the M write wins.
  - Destination 0xF means no write.
- **New PC**
  - call: valC.
  - jXX: valC if cnd, else valP.
  - ret: valM.
  - All others: valP.
- **Status priority:** ADR (imem_error) > INS (!instr_valid) > HLT (icode 0) > AOK.
- When stat ≠ AOK, the cycle commits nothing: no PC, register or CC update. The core stays frozen until reset.
- Program loads through imem_we are allowed at any time, including during reset. Instruction memory is not cleared by reset.

## Timing
- Fetch, decode and execute are purely combinational from pc and state. One instruction commits per clock.
- On each rising edge with stat = AOK, the PC, register writes and CC update occur together.
- valM must be stable before the rising edge.
- Reset (synchronous) sets:
  - pc = 0.
  - All 15 registers = 0.
  - ZF = 1, SF = 0, OF = 0.
  - stat derives from the fetch at address 0.
- Reset asserted mid-program takes effect at the next edge and overrides every commit in that cycle.
- An imem write and a fetch of the same byte in the same cycle: the fetch sees the old byte.

## Test plan
- **irmovq:** load `30 F2 0A00…00` at 0, then reset. The cycle after reset shows valC = 10, valE = 10, valP = 10. The next edge leaves r2 = 10 and pc = 10.
- **OPq sub:** with r2 = 10 and r3 = 3, execute subq r2,r3 (`61 23`). Result r3 = −7, SF = 1, ZF = 0, OF = 0. A following jl (`72`) branches to its valC with cnd = 1.
- **Conditional move:** after a subq giving zero, cmove (`23`) writes the target and cmovne (`24`) leaves the target unchanged.
- **call/ret:** with rsp = 0x100, call writes rsp = 0xF8 and pc = valC. A ret with valM = 0x40 sets pc = 0x40 and rsp = 0x100.
- **Status:** byte 0xC0 gives stat = INS with state frozen. A halt gives stat = HLT and pc holds. A 10-byte instruction at 1020 gives imem_error = 1 and stat = ADR.
- **Overflow:** addq of 0x7FFF…FFFF + 1 gives OF = 1 and SF = 1. Reset asserted mid-run returns pc to 0 and clears all registers.
